// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the sequence-detector FSMs.
// A WIDTH-bit word is taken over a valid/ready handshake and shifted out one
// bit per clock on 'data'. In the last-bit cycle a new word can be accepted,
// so consecutive words stream with no idle gap.

module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             data,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] shifted;
  logic             accept;

  // Ready depends only on state and counter, so it never waits on load_valid.
  always_comb begin
    load_ready = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST_IDX));
    accept     = load_valid && load_ready;
  end

  // Next-state and next-output logic; the shift register always holds the
  // word aligned so the bit currently on 'data' sits at the outgoing end.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = IDLE_LEVEL;
    valid_d = 1'b0;
    done_d  = 1'b0;
    shifted = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

    if (accept) begin
      state_d = SHIFT;
      shift_d = load_data;
      cnt_d   = '0;
      data_d  = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
      valid_d = 1'b1;
    end else if (state_q == SHIFT) begin
      if (cnt_q == LAST_IDX) begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end else begin
        shift_d = shifted;
        cnt_d   = cnt_q + CW'(1);
        data_d  = MSB_FIRST ? shifted[WIDTH-1] : shifted[0];
        valid_d = 1'b1;
        done_d  = ((cnt_q + CW'(1)) == LAST_IDX);
      end
    end

    busy_d = valid_d;
  end

  // State and registered outputs; reset discards any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= IDLE_LEVEL;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: drives an MSB-first and an LSB-first serializer from a
// vector table, scoreboards every serial bit, and models a 101 detector on
// the MSB-first stream.

module tb_bit_serializer;

  typedef struct packed {
    logic b;
    logic d;
  } exp_t;

  typedef struct {
    bit         lsb;
    logic [7:0] word;
    logic [7:0] stream;
    bit         keep;
    int         expRun;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] ldDataM, ldDataL;
  logic       ldValidM, ldValidL;
  logic       readyM, readyL;
  logic       dataM, dataL;
  logic       dvM, dvL;
  logic       busyM, busyL;
  logic       doneM, doneL;

  exp_t qM[$];
  exp_t qL[$];
  int   checks = 0;
  int   errors = 0;
  int   runM = 0, runL = 0, lastRunM = 0, lastRunL = 0;

  bit   detOn = 1'b0;
  int   detIdx = 0;
  int   detState = 0;
  int   detHits[$];

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dutM (
    .clk(clk), .rst(rst), .load_data(ldDataM), .load_valid(ldValidM),
    .load_ready(readyM), .data(dataM), .data_valid(dvM), .busy(busyM), .done(doneM)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dutL (
    .clk(clk), .rst(rst), .load_data(ldDataL), .load_valid(ldValidL),
    .load_ready(readyL), .data(dataL), .data_valid(dvL), .busy(busyL), .done(doneL)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  // Scoreboard for the MSB-first instance: every payload bit must match the
  // next queued bit; idle cycles must hold the idle level.
  always @(negedge clk) begin
    exp_t e;
    checkOutput("M busy==data_valid", 32'(busyM), 32'(dvM));
    if (dvM) begin
      runM++;
      if (qM.size() == 0) begin
        failNow("M unexpected payload bit");
      end else begin
        e = qM.pop_front();
        checkOutput("M data", 32'(dataM), 32'(e.b));
        checkOutput("M done", 32'(doneM), 32'(e.d));
        checkOutput("M load_ready busy", 32'(readyM), 32'(e.d));
      end
    end else begin
      if (runM != 0) begin
        lastRunM = runM;
        runM = 0;
      end
      checkOutput("M idle data", 32'(dataM), 32'(1'b0));
      checkOutput("M idle done", 32'(doneM), 32'(1'b0));
      checkOutput("M idle load_ready", 32'(readyM), 32'(1'b1));
    end
  end

  // Scoreboard for the LSB-first instance, same rules.
  always @(negedge clk) begin
    exp_t e;
    checkOutput("L busy==data_valid", 32'(busyL), 32'(dvL));
    if (dvL) begin
      runL++;
      if (qL.size() == 0) begin
        failNow("L unexpected payload bit");
      end else begin
        e = qL.pop_front();
        checkOutput("L data", 32'(dataL), 32'(e.b));
        checkOutput("L done", 32'(doneL), 32'(e.d));
        checkOutput("L load_ready busy", 32'(readyL), 32'(e.d));
      end
    end else begin
      if (runL != 0) begin
        lastRunL = runL;
        runL = 0;
      end
      checkOutput("L idle data", 32'(dataL), 32'(1'b0));
      checkOutput("L idle done", 32'(doneL), 32'(1'b0));
      checkOutput("L idle load_ready", 32'(readyL), 32'(1'b1));
    end
  end

  // Reference 101 non-overlapping Mealy detector fed by the MSB-first stream.
  always @(negedge clk) begin
    if (detOn && dvM) begin
      detIdx++;
      case (detState)
        0: detState = dataM ? 1 : 0;
        1: detState = dataM ? 1 : 2;
        default: begin
          if (dataM) detHits.push_back(detIdx);
          detState = 0;
        end
      endcase
    end
  end

  // Wait for ready at a negedge, present the word, and queue its expected
  // bit stream (leftmost bit of 'stream' goes out first).
  task automatic applyStimulus(input bit lsb, input logic [7:0] word,
                               input logic [7:0] stream, input bit keep);
    bit ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if ((lsb ? readyL : readyM) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      failNow("timeout waiting for load_ready");
      return;
    end
    for (int i = 7; i >= 0; i--) begin
      if (lsb) qL.push_back('{b: stream[i], d: (i == 0)});
      else     qM.push_back('{b: stream[i], d: (i == 0)});
    end
    if (lsb) begin ldDataL = word; ldValidL = 1'b1; end
    else     begin ldDataM = word; ldValidM = 1'b1; end
    @(posedge clk);
    #1;
    if (!keep) begin
      if (lsb) ldValidL = 1'b0;
      else     ldValidM = 1'b0;
    end
  endtask

  task automatic waitIdle(input bit lsb);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      #1;
      if (lsb ? (qL.size() == 0 && !dvL) : (qM.size() == 0 && !dvM)) return;
    end
    failNow("timeout waiting for idle");
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{lsb: 1'b0, word: 8'b1010_1010, stream: 8'b1010_1010, keep: 1'b0, expRun: 8};
    vecs[1] = '{lsb: 1'b0, word: 8'hA5,       stream: 8'b1010_0101, keep: 1'b1, expRun: 0};
    vecs[2] = '{lsb: 1'b0, word: 8'h3C,       stream: 8'b0011_1100, keep: 1'b0, expRun: 16};
    vecs[3] = '{lsb: 1'b1, word: 8'b0000_0101, stream: 8'b1010_0000, keep: 1'b0, expRun: 8};
    vecs[4] = '{lsb: 1'b1, word: 8'hD2,       stream: 8'b0100_1011, keep: 1'b0, expRun: 8};
    vecs[5] = '{lsb: 1'b0, word: 8'h01,       stream: 8'b0000_0001, keep: 1'b0, expRun: 8};
    vecs[6] = '{lsb: 1'b1, word: 8'h80,       stream: 8'b0000_0001, keep: 1'b0, expRun: 8};

    rst = 1'b1;
    ldDataM = 8'h00; ldDataL = 8'h00;
    ldValidM = 1'b0; ldValidL = 1'b0;

    // Reset held for two cycles: everything idle, ready high.
    repeat (2) begin
      @(negedge clk);
      #1;
      checkOutput("reset data", 32'(dataM), 32'(1'b0));
      checkOutput("reset data_valid", 32'(dvM), 32'(1'b0));
      checkOutput("reset busy", 32'(busyM), 32'(1'b0));
      checkOutput("reset done", 32'(doneM), 32'(1'b0));
      checkOutput("reset load_ready", 32'(readyM), 32'(1'b1));
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("post-reset load_ready", 32'(readyM), 32'(1'b1));

    // Table-driven words, including a back-to-back pair.
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].lsb, vecs[v].word, vecs[v].stream, vecs[v].keep);
      if (!vecs[v].keep) begin
        waitIdle(vecs[v].lsb);
        checkOutput($sformatf("run length vec%0d", v),
                    32'(vecs[v].lsb ? lastRunL : lastRunM), 32'(vecs[v].expRun));
      end
    end

    // load_data wiggling with load_valid low must produce nothing.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ldDataM = 8'(i * 37 + 5);
    end
    @(negedge clk);
    #1;
    checkOutput("no accept without valid", 32'(dvM), 32'(1'b0));

    // Async reset in the middle of 8'hFF: outputs drop at once, no residue.
    applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("mid-word bit4 valid", 32'(dvM), 32'(1'b1));
    rst = 1'b1;
    #1;
    checkOutput("async reset data", 32'(dataM), 32'(1'b0));
    checkOutput("async reset data_valid", 32'(dvM), 32'(1'b0));
    checkOutput("async reset done", 32'(doneM), 32'(1'b0));
    qM.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("no residual after reset", 32'(dvM), 32'(1'b0));
    applyStimulus(1'b0, 8'hC3, 8'hC3, 1'b0);
    waitIdle(1'b0);
    checkOutput("clean word after reset run", 32'(lastRunM), 32'd8);

    // Stream 8'b1010_1010 twice into the reference detector.
    detIdx = 0;
    detState = 0;
    detHits.delete();
    detOn = 1'b1;
    applyStimulus(1'b0, 8'hAA, 8'hAA, 1'b1);
    applyStimulus(1'b0, 8'hAA, 8'hAA, 1'b0);
    waitIdle(1'b0);
    detOn = 1'b0;
    checkOutput("detector hit count", 32'(detHits.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("detector hit %0d", i),
                  (i < detHits.size()) ? 32'(detHits[i]) : 32'hFFFF_FFFF, 32'(3 + 4 * i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
